// File: rtl/truth_table_sweeper.sv
// Exhaustive truth-table sweeper: steps stim through every input vector, compares resp to expected.
// Optional MISR response signature enabled with `define SWEEP_MISR_EN.
module truth_table_sweeper #(
  parameter int N_IN  = 4,
  parameter int N_OUT = 2,
  parameter int DWELL = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic [N_IN-1:0]  stim,
  input  logic [N_OUT-1:0] resp,
  input  logic [N_OUT-1:0] expected,
  output logic             busy,
  output logic             done,
  output logic [N_IN:0]    mismatch_cnt,
  output logic             fail_valid,
  output logic [N_IN-1:0]  first_fail_idx
`ifdef SWEEP_MISR_EN
  ,
  output logic [15:0]      signature
`endif
);

  localparam int DW = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [DW-1:0]   DWELL_LAST = DW'(DWELL - 1);
  localparam logic [DW-1:0]   DW_ONE     = DW'(1);
  localparam logic [N_IN-1:0] STIM_ONE   = N_IN'(1);
  localparam logic [N_IN-1:0] LAST_VEC   = '1;
  localparam logic [N_IN:0]   CNT_ONE    = (N_IN + 1)'(1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t            state, state_d;
  logic [DW-1:0]     dwell_cnt, dwell_d;
  logic [N_IN-1:0]   stim_d, ffi_d;
  logic [N_IN:0]     cnt_d;
  logic              fv_d, busy_d, done_d;
  logic              sample, miss;
`ifdef SWEEP_MISR_EN
  logic [15:0]       sig_d;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      dwell_cnt      <= '0;
      stim           <= '0;
      mismatch_cnt   <= '0;
      fail_valid     <= 1'b0;
      first_fail_idx <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
`ifdef SWEEP_MISR_EN
      signature      <= '0;
`endif
    end else begin
      state          <= state_d;
      dwell_cnt      <= dwell_d;
      stim           <= stim_d;
      mismatch_cnt   <= cnt_d;
      fail_valid     <= fv_d;
      first_fail_idx <= ffi_d;
      busy           <= busy_d;
      done           <= done_d;
`ifdef SWEEP_MISR_EN
      signature      <= sig_d;
`endif
    end
  end

  // Each vector is judged once, on the last cycle of its dwell window.
  assign sample = (state == RUN) && (dwell_cnt == DWELL_LAST);
  assign miss   = sample && (resp != expected);

  always_comb begin
    state_d = state;
    dwell_d = dwell_cnt;
    stim_d  = stim;
    cnt_d   = mismatch_cnt;
    fv_d    = fail_valid;
    ffi_d   = first_fail_idx;
    busy_d  = busy;
    done_d  = done;
`ifdef SWEEP_MISR_EN
    sig_d   = signature;
`endif
    case (state)
      IDLE, DONE: begin
        if (start) begin
          state_d = RUN;
          dwell_d = '0;
          stim_d  = '0;
          cnt_d   = '0;
          fv_d    = 1'b0;
          ffi_d   = '0;
          busy_d  = 1'b1;
          done_d  = 1'b0;
`ifdef SWEEP_MISR_EN
          sig_d   = 16'hFFFF;
`endif
        end
      end
      RUN: begin
        if (sample) begin
          dwell_d = '0;
          if (miss) begin
            cnt_d = mismatch_cnt + CNT_ONE;
            if (!fail_valid) begin
              fv_d  = 1'b1;
              ffi_d = stim;
            end
          end
`ifdef SWEEP_MISR_EN
          sig_d = {signature[14:0], 1'b0} ^ (signature[15] ? 16'h1021 : 16'h0000) ^ 16'(resp);
`endif
          if (stim == LAST_VEC) begin
            state_d = DONE;
            stim_d  = '0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            stim_d = stim + STIM_ONE;
          end
        end else begin
          dwell_d = dwell_cnt + DW_ONE;
        end
      end
      default: begin
        state_d = IDLE;
        stim_d  = '0;
        busy_d  = 1'b0;
        done_d  = 1'b0;
      end
    endcase
  end

endmodule

// File: doc/truth_table_sweeper.md
TRUTH_TABLE_SWEEPER -- requirements
Module: truth_table_sweeper

Interface
REQ-001 SHALL have parameter N_IN, default 4, meaning width of the stimulus vector (1..16).
REQ-002 SHALL have parameter N_OUT, default 2, meaning width of the DUT response (1..16).
REQ-003 SHALL have parameter DWELL, default 10, meaning clock cycles each vector is held (>=1).
REQ-004 SHALL have port clk  input  1  the single clock; all state on rising edge.
REQ-005 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port start  input  1  one-cycle request to begin a sweep.
REQ-007 SHALL have port stim  output  N_IN  vector driven to the DUT inputs.
REQ-008 SHALL have port resp  input  N_OUT  DUT outputs.
REQ-009 SHALL have port expected  input  N_OUT  golden-model outputs for the current stim.
REQ-010 SHALL have port busy  output  1  high while sweeping.
REQ-011 SHALL have port done  output  1  high once a sweep completes, held until the next start or reset.
REQ-012 SHALL have port mismatch_cnt  output  N_IN+1  number of failing vectors.
REQ-013 SHALL have port fail_valid  output  1  at least one mismatch seen this sweep.
REQ-014 SHALL have port first_fail_idx  output  N_IN  stim value of the first failing vector.

Function
REQ-015 SHALL implement FSM states IDLE, RUN, DONE; IDLE->RUN on start, RUN->DONE after the last vector, DONE->RUN on start.
REQ-016 SHALL ignore start while in RUN.
REQ-017 SHALL, on the edge E0 that accepts start, set stim=0, clear mismatch_cnt, fail_valid, first_fail_idx and dwell counter, set busy=1, done=0.
REQ-018 SHALL hold vector k on stim from edge E0+k*DWELL until edge E0+(k+1)*DWELL, for k = 0..2^N_IN-1.
REQ-019 SHALL compare resp against expected once per vector, at edge E0+(k+1)*DWELL (dwell counter = DWELL-1), then increment stim.
REQ-020 SHALL, on a mismatch, increment mismatch_cnt by 1; mismatch_cnt never wraps, since its width holds 2^N_IN.
REQ-021 SHALL, on the first mismatch of a sweep, capture stim into first_fail_idx and set fail_valid; later mismatches leave first_fail_idx unchanged.
REQ-022 SHALL, at the sample edge of vector 2^N_IN-1, enter DONE: busy=0, done=1, stim=0; there is no wrap to vector 0.
REQ-023 SHALL drive stim=0 in IDLE and DONE; result outputs hold their values in DONE.
REQ-024 SHALL take exactly DWELL*2^N_IN cycles from start acceptance to done (160 at defaults).
REQ-025 SHALL treat DWELL=1 as one vector per cycle, with a compare every edge.

Reset
REQ-026 SHALL, on rst high, asynchronously force IDLE, with stim, busy, done, mismatch_cnt, fail_valid, first_fail_idx and the dwell counter all 0.
REQ-027 SHALL abort an in-progress sweep on reset; no partial results are retained.
REQ-028 SHALL leave IDLE only on a start sampled after rst deasserts.

Configuration
REQ-029 SHALL, with macro SWEEP_MISR_EN defined, add output signature (16 bits): seed 16'hFFFF at start acceptance; at each sample edge next = {sig[14:0],1'b0} XOR (sig[15] ? 16'h1021 : 0) XOR zero-extended resp; reset value 0; held in DONE.
REQ-030 SHALL, without SWEEP_MISR_EN, omit the signature port and logic entirely; all other behaviour is identical.

Verification
REQ-031 SHALL cover: defaults, resp tied to expected, start pulse -> stim steps 0..15 every 10 cycles, done at +160 cycles, mismatch_cnt=0, fail_valid=0.
REQ-032 SHALL cover: resp forced to differ from expected on vectors 5 and 12 -> mismatch_cnt=2, first_fail_idx=5, fail_valid=1.
REQ-033 SHALL cover: rst pulsed while stim=7 -> all outputs 0 immediately (asynchronously), FSM in IDLE; a new start sweeps from vector 0.
REQ-034 SHALL cover: start re-pulsed mid-sweep -> ignored, done still at +160; start in DONE -> results cleared, new 160-cycle sweep.
REQ-035 SHALL cover: DWELL=1, N_IN=3 -> 8 vectors in 8 cycles, done on the 8th edge after acceptance.
REQ-036 SHALL cover: SWEEP_MISR_EN with resp=expected=stim[1:0] -> signature equals the bench model value; one flipped resp bit -> signature differs.
